// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master drives a request; the slave returns status and results.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-add/full-subtract slice per clock,
// LSB first, with the carry/borrow kept in a single flop between steps.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             mode_q, carry_q, cout_q, ovf_q, busy_q, done_q;

  logic             x, y, r, carry_d, ovf_d, last_bit;
  logic [WIDTH-1:0] sum_d;

  // Operands shift right each step, so bit 0 always holds the current slice;
  // on the final step it is the MSB, which is what the overflow rule needs.
  always_comb begin
    x        = a_q[0];
    y        = b_q[0];
    r        = x ^ y ^ carry_q;
    carry_d  = mode_q ? ((~x & y) | (~x & carry_q) | (y & carry_q))
                      : ((x & y) | (y & carry_q) | (x & carry_q));
    ovf_d    = mode_q ? ((x != y) && (r != x)) : ((x == y) && (r != x));
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    sum_d            = sum_q >> 1;
    sum_d[WIDTH-1]   = r;
    last_bit         = (cnt_q == CW'(WIDTH - 1));
  end

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            mode_q  <= bus.mode;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          // Results are published only on the last slice so they stay stable while busy.
          if (last_bit) begin
            result_q <= sum_d;
            cout_q   <= carry_d;
            ovf_q    <= ovf_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed vector table, multi-cycle
// corner sequences, and randomized operations against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for result/carry, signed for overflow.
  task automatic ref_model(input bit m, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit c, output logic [W-1:0] r, output bit co, output bit ov);
    int ua, ub, sa, sb, ci, u, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = c ? 1 : 0;
    u  = m ? (ua - ub - ci) : (ua + ub + ci);
    s  = m ? (sa - sb - ci) : (sa + sb + ci);
    r  = u[W-1:0];
    co = m ? (u < 0) : (u > (1 << W) - 1);
    ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
  endtask

  task automatic start_op(input bit m, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
    bus.mode  = m;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    bus.start = 1'b1;
  endtask

  // Called at a negedge after start_op; returns at the negedge where done is seen.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) return;
    end
  endtask

  task automatic run_and_check(input string name, input bit m, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit c, input logic [W-1:0] er,
                               input bit eco, input bit eov);
    int edges;
    start_op(m, a, b, c);
    wait_done(edges);
    check({name, "_latency"}, edges, W + 1);
    check({name, "_result"}, bus.result, er);
    check({name, "_cout"}, bus.cout, eco);
    check({name, "_ovf"}, bus.overflow, eov);
  endtask

  // Protocol monitor: done lasts one cycle and never coincides with busy.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      check("done_width", prev_done, 1'b0);
      check("busy_with_done", bus.busy, 1'b0);
    end
    prev_done = rst_n ? bus.done : 1'b0;
  end

  typedef struct {
    bit             mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             cin;
    logic [W-1:0]   r;
    bit             co;
    bit             ov;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           edges;
    bit           saw_done;
    bit           m, c, ex_co, ex_ov;
    logic [W-1:0] a, b, ex_r;

    vecs[0] = '{1'b0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h05, 8'h02, 1'b1, 8'h02, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 8'h00);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].r, vecs[i].co, vecs[i].ov);
      @(negedge clk);
    end

    // start during RUN is ignored; start during DONE is accepted back-to-back
    start_op(1'b0, 8'h35, 8'h4A, 1'b0);
    edges = 0;
    @(posedge clk); edges++;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    check("run_busy", bus.busy, 1'b1);
    start_op(1'b1, 8'hFF, 8'hFF, 1'b1);
    @(posedge clk); edges++;
    @(negedge clk); bus.start = 1'b0;
    while (!bus.done && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    check("ignore_latency", edges, W + 1);
    check("ignore_result", bus.result, 8'h7F);
    check("ignore_cout", bus.cout, 1'b0);
    run_and_check("b2b", 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);

    // Reset mid-operation abandons it
    @(negedge clk);
    start_op(1'b0, 8'hFF, 8'hFF, 1'b0);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_result", bus.result, 8'h00);
    check("midrst_cout", bus.cout, 1'b0);
    check("midrst_ovf", bus.overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_done |= bus.done;
    end
    check("no_done_after_rst", saw_done, 1'b0);
    run_and_check("post_rst", 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    // Randomized operations, mixing back-to-back and idle gaps
    for (int i = 0; i < 1000; i++) begin
      m = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      ref_model(m, a, b, c, ex_r, ex_co, ex_ov);
      run_and_check($sformatf("rnd%0d", i), m, a, b, c, ex_r, ex_co, ex_ov);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
